// File: rtl/vault_pkg.sv
// Shared types and constants for the vault datapath front end:
// quadrature decoder state encoding, default position width and
// direction codes reported on the dir output.
package vault_pkg;

    typedef enum logic [2:0] {
        INIT = 3'd0,
        Q00  = 3'd1,
        Q01  = 3'd2,
        Q11  = 3'd3,
        Q10  = 3'd4
    } quad_state_t;

    localparam int   DEFAULT_POS_WIDTH = 8;
    localparam logic DIR_UP            = 1'b1;
    localparam logic DIR_DOWN          = 1'b0;

    // Map a debounced {A,B} pair onto its decoder state
    function automatic quad_state_t ab_to_state(input logic [1:0] ab);
        case (ab)
            2'b00:   return Q00;
            2'b01:   return Q01;
            2'b11:   return Q11;
            default: return Q10;
        endcase
    endfunction

    // Next state in the clockwise sequence 00->01->11->10->00
    function automatic quad_state_t cw_next(input quad_state_t s);
        case (s)
            Q00:     return Q01;
            Q01:     return Q11;
            Q11:     return Q10;
            Q10:     return Q00;
            default: return INIT;
        endcase
    endfunction

    // Next state in the counter-clockwise sequence 00->10->11->01->00
    function automatic quad_state_t ccw_next(input quad_state_t s);
        case (s)
            Q00:     return Q10;
            Q10:     return Q11;
            Q11:     return Q01;
            Q01:     return Q00;
            default: return INIT;
        endcase
    endfunction

endpackage

// File: rtl/re_debounce.sv
// One encoder channel: two-flop synchroniser followed by a debouncer.
// The stable output only follows the synchronised pin after it has
// differed from the current stable value for DEBOUNCE_CYCLES clocks
// in a row; any return to the stable value restarts the count.
module re_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic n_reset,
    input  logic raw_in,
    output logic stable
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;

    // Bring the asynchronous pin into the clock domain
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) sync_q <= '0;
        else          sync_q <= {sync_q[0], raw_in};
    end

    // Count consecutive disagreeing clocks and accept the new level on the last one
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            stable <= 1'b0;
            cnt_q  <= '0;
        end else if (sync_q[1] == stable) begin
            cnt_q <= '0;
        end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            stable <= sync_q[1];
            cnt_q  <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/rotary_encoder_if.sv
// Rotary encoder front end: debounces the A/B pins, decodes quadrature
// transitions into a signed sub-step count, and turns full detents into
// a wrapping dial position with step/dir/quad_err pulses.
// Build option: ROTARY_GRAY_OUT_EN presents position Gray-coded
// (registered alongside the binary counter, so latency is unchanged).
module rotary_encoder_if #(
    parameter int DEBOUNCE_CYCLES  = 4,
    parameter int STEPS_PER_DETENT = 4,
    parameter int POS_WIDTH        = vault_pkg::DEFAULT_POS_WIDTH
) (
    input  logic                 clock,
    input  logic                 n_reset,
    input  logic                 enc_a,
    input  logic                 enc_b,
    input  logic                 zero_req,
    output logic [POS_WIDTH-1:0] position,
    output logic                 step,
    output logic                 dir,
    output logic                 quad_err
);

    import vault_pkg::*;

    localparam int IW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int SW = $clog2(STEPS_PER_DETENT) + 2;

    localparam logic signed [SW-1:0] SUB_ONE = SW'(1);
    localparam logic signed [SW-1:0] STEP_P  = SW'(STEPS_PER_DETENT);
    localparam logic signed [SW-1:0] STEP_N  = -STEP_P;

    logic a_stable;
    logic b_stable;

    quad_state_t            state_q, state_d, ab_state;
    logic [IW-1:0]          init_cnt_q, init_cnt_d;
    logic signed [SW-1:0]   sub_cnt_q, sub_cnt_d, sub_calc;
    logic [POS_WIDTH-1:0]   pos_q, pos_d;
    logic                   step_d, dir_d, err_d;

    re_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
        .clock   (clock),
        .n_reset (n_reset),
        .raw_in  (enc_a),
        .stable  (a_stable)
    );

    re_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
        .clock   (clock),
        .n_reset (n_reset),
        .raw_in  (enc_b),
        .stable  (b_stable)
    );

    // Register decoder state, sub-step count, position and output pulses
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
            sub_cnt_q  <= '0;
            pos_q      <= '0;
            step       <= 1'b0;
            dir        <= DIR_DOWN;
            quad_err   <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            sub_cnt_q  <= sub_cnt_d;
            pos_q      <= pos_d;
            step       <= step_d;
            dir        <= dir_d;
            quad_err   <= err_d;
        end
    end

    // Decode transitions, accumulate sub-steps into detents, apply zero_req last
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        pos_d      = pos_q;
        step_d     = 1'b0;
        dir_d      = dir;
        err_d      = 1'b0;
        sub_calc   = sub_cnt_q;
        ab_state   = ab_to_state({a_stable, b_stable});

        case (state_q)
            INIT: begin
                if (init_cnt_q == IW'(DEBOUNCE_CYCLES - 1)) state_d = ab_state;
                else                                        init_cnt_d = init_cnt_q + IW'(1);
            end
            default: begin
                if (ab_state != state_q) begin
                    state_d = ab_state;
                    if (ab_state == cw_next(state_q))       sub_calc = sub_cnt_q + SUB_ONE;
                    else if (ab_state == ccw_next(state_q)) sub_calc = sub_cnt_q - SUB_ONE;
                    else                                    err_d = 1'b1;
                end
            end
        endcase

        if (sub_calc == STEP_P) begin
            pos_d    = pos_q + POS_WIDTH'(1);
            sub_calc = '0;
            step_d   = 1'b1;
            dir_d    = DIR_UP;
        end else if (sub_calc == STEP_N) begin
            pos_d    = pos_q - POS_WIDTH'(1);
            sub_calc = '0;
            step_d   = 1'b1;
            dir_d    = DIR_DOWN;
        end

        sub_cnt_d = sub_calc;

        if (zero_req) begin
            pos_d     = '0;
            sub_cnt_d = '0;
            step_d    = 1'b0;
            dir_d     = dir;
        end
    end

`ifdef ROTARY_GRAY_OUT_EN
    logic [POS_WIDTH-1:0] pos_gray_q;

    // Register the Gray view of the next binary position so both update together
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) pos_gray_q <= '0;
        else          pos_gray_q <= pos_d ^ (pos_d >> 1);
    end

    assign position = pos_gray_q;
`else
    assign position = pos_q;
`endif

endmodule

// File: tb/tb_rotary_encoder_if.sv
// Scoreboard bench for rotary_encoder_if: stimulus pushes the expected
// step/quad_err events (kind, position, dir, cycle) and a negedge monitor
// pops and compares them whenever the DUT pulses an output.
module tb_rotary_encoder_if;

    typedef struct {
        bit   is_err;
        int   pos;
        logic dir;
        int   cyc;
    } exp_t;

    localparam int KIND_NONE = 0;
    localparam int KIND_STEP = 1;
    localparam int KIND_ERR  = 2;

    logic       clock = 1'b0;
    logic       n_reset;
    logic       enc_a;
    logic       enc_b;
    logic       zero_req;
    logic [7:0] position;
    logic       step;
    logic       dir;
    logic       quad_err;

    int   checks   = 0;
    int   failures = 0;
    int   cycle    = 0;
    exp_t sb[$];

    rotary_encoder_if #(
        .DEBOUNCE_CYCLES  (4),
        .STEPS_PER_DETENT (4),
        .POS_WIDTH        (8)
    ) dut (
        .clock    (clock),
        .n_reset  (n_reset),
        .enc_a    (enc_a),
        .enc_b    (enc_b),
        .zero_req (zero_req),
        .position (position),
        .step     (step),
        .dir      (dir),
        .quad_err (quad_err)
    );

    always #5 clock = ~clock;

    // Cycle counter used to timestamp expected events
    always @(posedge clock) cycle <= cycle + 1;

    // Expected position encoding seen on the output pins
    function automatic int exp_pos(input int b);
        logic [7:0] v;
        v = b[7:0];
`ifdef ROTARY_GRAY_OUT_EN
        return int'(v ^ (v >> 1));
`else
        return int'(v);
`endif
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d required=%0d cycle=%0d", name, actual, expected, cycle);
        end
    endtask

    // Drive a pin pair, optionally queue the event it must produce, then hold
    task automatic applyStimulus(input logic [1:0] ab, input int hold,
                                 input int kind, input int pos, input logic d,
                                 output int edge_cyc);
        exp_t e;
        {enc_a, enc_b} = ab;
        edge_cyc = cycle;
        if (kind != KIND_NONE) begin
            e.is_err = (kind == KIND_ERR);
            e.pos    = pos;
            e.dir    = d;
            e.cyc    = edge_cyc + 7;
            sb.push_back(e);
        end
        repeat (hold) @(negedge clock);
    endtask

    // Monitor: every output pulse must match the oldest queued expectation
    always @(negedge clock) begin
        exp_t e;
        if (n_reset === 1'b1 && (step === 1'b1 || quad_err === 1'b1)) begin
            checkOutput("step_err_exclusive", int'(step & quad_err), 0);
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_event step=%0b quad_err=%0b position=%0d cycle=%0d",
                         step, quad_err, position, cycle);
            end else begin
                e = sb.pop_front();
                checkOutput("event_kind_err", int'(quad_err), int'(e.is_err));
                checkOutput("event_position", int'(position), exp_pos(e.pos));
                checkOutput("event_dir", int'(dir), int'(e.dir));
                checkOutput("event_cycle", cycle, e.cyc);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired cycle=%0d", cycle);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int ec;
        n_reset  = 1'b0;
        enc_a    = 1'b0;
        enc_b    = 1'b0;
        zero_req = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("reset_position", int'(position), exp_pos(0));
        checkOutput("reset_step", int'(step), 0);
        checkOutput("reset_dir", int'(dir), 0);
        checkOutput("reset_quad_err", int'(quad_err), 0);

        n_reset = 1'b1;
        repeat (20) @(negedge clock);
        checkOutput("idle_position", int'(position), exp_pos(0));

        // One clockwise detent with exact latency on the completing edge
        applyStimulus(2'b01, 10, KIND_NONE, 0, 1'b0, ec);
        applyStimulus(2'b11, 10, KIND_NONE, 0, 1'b0, ec);
        applyStimulus(2'b10, 10, KIND_NONE, 0, 1'b0, ec);
        applyStimulus(2'b00, 6, KIND_STEP, 1, 1'b1, ec);
        checkOutput("latency_minus1_position", int'(position), exp_pos(0));
        @(negedge clock);
        checkOutput("latency_position", int'(position), exp_pos(1));
        repeat (3) @(negedge clock);

        // Clear position before the counter-clockwise detent
        zero_req = 1'b1;
        @(negedge clock);
        zero_req = 1'b0;
        checkOutput("zero_req_position", int'(position), exp_pos(0));
        repeat (2) @(negedge clock);

        // Counter-clockwise detent wraps 0 -> 255
        applyStimulus(2'b10, 10, KIND_NONE, 0, 1'b0, ec);
        applyStimulus(2'b11, 10, KIND_NONE, 0, 1'b0, ec);
        applyStimulus(2'b01, 10, KIND_NONE, 0, 1'b0, ec);
        applyStimulus(2'b00, 10, KIND_STEP, 255, 1'b0, ec);
        checkOutput("ccw_position", int'(position), exp_pos(255));
        checkOutput("ccw_dir", int'(dir), 0);

        // Short glitch on A must be rejected
        enc_a = 1'b1;
        repeat (3) @(negedge clock);
        enc_a = 1'b0;
        repeat (15) @(negedge clock);
        checkOutput("glitch_position", int'(position), exp_pos(255));

        // Illegal jumps 00->11 and back each raise quad_err only
        applyStimulus(2'b11, 10, KIND_ERR, 255, 1'b0, ec);
        applyStimulus(2'b00, 10, KIND_ERR, 255, 1'b0, ec);
        checkOutput("quad_err_position", int'(position), exp_pos(255));

        // zero_req lands with the fourth stable update: no step, position cleared
        applyStimulus(2'b01, 10, KIND_NONE, 0, 1'b0, ec);
        applyStimulus(2'b11, 10, KIND_NONE, 0, 1'b0, ec);
        applyStimulus(2'b10, 10, KIND_NONE, 0, 1'b0, ec);
        applyStimulus(2'b00, 6, KIND_NONE, 0, 1'b0, ec);
        zero_req = 1'b1;
        @(negedge clock);
        zero_req = 1'b0;
        repeat (5) @(negedge clock);
        checkOutput("zero_priority_position", int'(position), exp_pos(0));

        // 256 clockwise detents wrap back to 0
        for (int i = 0; i < 256; i++) begin
            applyStimulus(2'b01, 10, KIND_NONE, 0, 1'b0, ec);
            applyStimulus(2'b11, 10, KIND_NONE, 0, 1'b0, ec);
            applyStimulus(2'b10, 10, KIND_NONE, 0, 1'b0, ec);
            applyStimulus(2'b00, 10, KIND_STEP, (i + 1) % 256, 1'b1, ec);
            if (i == 2) checkOutput("after_3_detents_position", int'(position), exp_pos(3));
        end
        checkOutput("wrap_position", int'(position), exp_pos(0));

        repeat (10) @(negedge clock);
        checkOutput("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
